switch_display_ctrl: RTL

Parametrised front-panel controller between the board switches/buttons and the display path (bin_to_bcd plus seven-segment driver). It synchronises and debounces four buttons, stores switch snapshots in a circular bank of SLOTS registers, selects a live or stored source, and applies hex/decimal display mode with decimal-overflow flagging. All outputs are registered.

---
 rtl/switch_display_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/switch_display_ctrl.sv
// Purpose : front-panel controller. Synchronises and debounces four buttons, keeps a circular
//           bank of switch snapshots, and selects a live or stored value with hex/dec display mode.
// Latency : switches to display_value is 3 cycles (LIVE). A button release acts D+2 cycles after it is sampled.
// Backpr. : none. Every input is sampled each cycle and every output is registered.
//
// Ports   : clk, reset (async, active-low)
//           switches_in  raw switch levels
//           btn_mode/btn_source/btn_store/btn_next  raw buttons; each acts on its debounced release
//           display_value, dec_mode, ovf, led_out  registered display outputs
//           rd_slot  slot being read;  slot_valid  bit i is set once slot i has been written
module switch_display_ctrl #(
    parameter int WIDTH           = 16,
    parameter int SLOTS           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DEC_MAX         = 9999
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         switches_in,
    input  logic                     btn_mode,
    input  logic                     btn_source,
    input  logic                     btn_store,
    input  logic                     btn_next,
    output logic [WIDTH-1:0]         display_value,
    output logic                     dec_mode,
    output logic                     ovf,
    output logic [WIDTH-1:0]         led_out,
    output logic [$clog2(SLOTS)-1:0] rd_slot,
    output logic [SLOTS-1:0]         slot_valid
);

    localparam int PW = $clog2(SLOTS);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] DEC_MAX_W = WIDTH'(DEC_MAX);

    localparam int B_MODE   = 0;
    localparam int B_SOURCE = 1;
    localparam int B_STORE  = 2;
    localparam int B_NEXT   = 3;

    typedef enum logic {MODE_HEX, MODE_DEC}   mode_t;
    typedef enum logic {SRC_LIVE, SRC_STORED} src_t;

    logic [3:0]       btn_raw;
    logic [3:0]       btn_s1, btn_s2;
    logic [WIDTH-1:0] sw_s1, sw_s2;
    logic [3:0]       btn_acc;
    logic [CW-1:0]    btn_cnt [4];
    logic [3:0]       pulse;

    mode_t mode_q, mode_d;
    src_t  src_q, src_d;

    logic [WIDTH-1:0] slot_q [SLOTS];
    logic [PW-1:0]    wr_ptr;
    logic [WIDTH-1:0] sel;
    logic             ovf_d;

    assign btn_raw = {btn_next, btn_store, btn_source, btn_mode};

    // Two-flop synchronisers for buttons and switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            sw_s1  <= switches_in;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: the counter runs only while the synchronised level disagrees with the
    // accepted level. Any agreeing sample clears it, so only an unbroken run of
    // DEBOUNCE_CYCLES differing samples is accepted. A pulse fires on an accepted release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_acc <= '0;
            pulse   <= '0;
            for (int i = 0; i < 4; i++) begin
                btn_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == btn_acc[i]) begin
                    btn_cnt[i] <= '0;
                    pulse[i]   <= 1'b0;
                end else if (btn_cnt[i] == CNT_LAST) begin
                    btn_acc[i] <= btn_s2[i];
                    btn_cnt[i] <= '0;
                    pulse[i]   <= ~btn_s2[i];
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                    pulse[i]   <= 1'b0;
                end
            end
        end
    end

    // Mode and source FSMs: state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_HEX;
            src_q  <= SRC_LIVE;
        end else begin
            mode_q <= mode_d;
            src_q  <= src_d;
        end
    end

    // Mode and source FSMs: next-state logic. Each pulse toggles its FSM.
    always_comb begin
        mode_d = mode_q;
        src_d  = src_q;
        if (pulse[B_MODE]) begin
            mode_d = (mode_q == MODE_HEX) ? MODE_DEC : MODE_HEX;
        end
        if (pulse[B_SOURCE]) begin
            src_d = (src_q == SRC_LIVE) ? SRC_STORED : SRC_LIVE;
        end
    end

    // Snapshot bank. A store writes at the old wr_ptr. The pointers wrap naturally
    // because SLOTS is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            slot_valid <= '0;
            wr_ptr     <= '0;
            rd_slot    <= '0;
        end else begin
            if (pulse[B_STORE]) begin
                slot_q[wr_ptr]     <= sw_s2;
                slot_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pulse[B_NEXT]) begin
                rd_slot <= rd_slot + 1'b1;
            end
        end
    end

    // Source select. A slot that has never been written reads as zero.
    always_comb begin
        sel = sw_s2;
        if (src_q == SRC_STORED) begin
            sel = slot_valid[rd_slot] ? slot_q[rd_slot] : '0;
        end
        ovf_d = (mode_q == MODE_DEC) && (sel > DEC_MAX_W);
    end

    // Output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            display_value <= '0;
            dec_mode      <= 1'b0;
            ovf           <= 1'b0;
            led_out       <= '0;
        end else begin
            display_value <= sel;
            dec_mode      <= (mode_q == MODE_DEC);
            ovf           <= ovf_d;
            led_out       <= {WIDTH{ovf_d}};
        end
    end

endmodule
